unified_buffer_mc: RTL and testbench

Parametrised, multi-channel successor of the two-lane unified buffer. Accepts up to NUM_CH words per cycle from the activation/ReLU path, compacts them into a linear scratchpad, and streams stored matrices back to the systolic array's input/weight accumulators. Reads are NUM_CH words per cycle in row-major or transposed (column) order. Sits between the post-activation stage and the array-feed accumulators; driven by ISA-decoded start/address/length fields.

---
 rtl/unified_buffer_pkg.sv | 18 +
 rtl/ub_lane_skew.sv | 33 +++
 rtl/unified_buffer_mc.sv | 220 ++++++++++++++++++++++
 tb/tb_unified_buffer_mc.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/unified_buffer_pkg.sv
// Shared types and defaults for the multi-channel unified buffer.
// Latency: none (types/functions only). Backpressure: n/a.
// Holds read FSM/mode enums and the lane-slice helper used for packed lane buses.
package unified_buffer_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 64;
    localparam int DEF_NUM_CH = 2;

    typedef enum logic { ROW = 1'b0, COL = 1'b1 } rd_mode_e;
    typedef enum logic { IDLE = 1'b0, READ = 1'b1 } rd_state_e;

    // LSB of lane `lane` within a packed bus of `width`-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/ub_lane_skew.sv
// Per-lane delay line used to build the systolic diagonal skew on read lanes.
// Latency: DELAY cycles (pass-through when DELAY is 0). Backpressure: none, free-running.
// Reset clears all stages so no stale beat leaks out after reset.
module ub_lane_skew #(
    parameter int WIDTH = 1,
    parameter int DELAY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DELAY == 0) begin : g_pass
            assign dout = din;
        end else begin : g_sr
            logic [WIDTH-1:0] sr [DELAY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DELAY; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= din;
                    for (int i = 1; i < DELAY; i++) sr[i] <= sr[i-1];
                end
            end

            assign dout = sr[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/unified_buffer_mc.sv
// Multi-channel scratchpad: compacts valid write lanes, streams row/column-ordered read beats.
// Latency: read beat k registered one cycle after issue; UB_SKEW_EN adds c cycles to lane c.
// Backpressure: none; full writes are dropped with a wr_overflow_out pulse, reads never stall.
module unified_buffer_mc
    import unified_buffer_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    parameter  int NUM_CH = DEF_NUM_CH,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_start,
    input  logic [NUM_CH-1:0]        wr_valid_in,
    input  logic [NUM_CH*DATA_W-1:0] wr_data_in,
    output logic [LEN_W-1:0]         wr_ptr_out,
    output logic                     wr_overflow_out,
    input  logic                     rd_start,
    input  logic                     rd_col_mode_in,
    input  logic [ADDR_W-1:0]        rd_addr_in,
    input  logic [LEN_W-1:0]         rd_len_in,
    output logic [NUM_CH*DATA_W-1:0] rd_data_out,
    output logic [NUM_CH-1:0]        rd_valid_out,
    output logic                     rd_busy_out,
    output logic                     rd_done_out
);

    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------- write path ----------------
    logic [LEN_W-1:0]  wr_ptr;
    logic              wr_ovf;
    logic [NUM_CH-1:0] wen;
    logic [ADDR_W-1:0] waddr [NUM_CH];
    int                wcnt;
    logic              wr_fit;

    always_comb begin
        int wa;
        wa   = 0;
        wcnt = 0;
        for (int c = 0; c < NUM_CH; c++) waddr[c] = '0;
        // Lanes land in ascending order at consecutive addresses, skipping invalid lanes.
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_valid_in[c]) begin
                wa       = int'(wr_ptr) + wcnt;
                waddr[c] = wa[ADDR_W-1:0];
                wcnt     = wcnt + 1;
            end
        end
        wr_fit = (int'(wr_ptr) + wcnt) <= DEPTH;
        wen    = (wr_start && wr_fit) ? wr_valid_in : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            wr_ovf <= 1'b0;
        end else begin
            wr_ovf <= 1'b0;
            if (wr_start && wcnt != 0) begin
                if (wr_fit) wr_ptr <= wr_ptr + LEN_W'(wcnt);
                else        wr_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++)
                if (wen[c]) mem[waddr[c]] <= wr_data_in[lane_lsb(c, DATA_W) +: DATA_W];
        end
    end

    assign wr_ptr_out      = wr_ptr;
    assign wr_overflow_out = wr_ovf;

    // ---------------- read path ----------------
    rd_state_e         state, state_n;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q, beat_q, nbeats_q;
    rd_mode_e          mode_q;
    logic              load, adv, last_shown;

    logic [ADDR_W-1:0]        g_base;
    logic [LEN_W-1:0]         g_len;
    rd_mode_e                 g_mode;
    int                       g_k, g_rows;
    logic [NUM_CH*DATA_W-1:0] g_data;
    logic [NUM_CH-1:0]        g_valid;
    logic                     g_last;

    logic [NUM_CH*DATA_W-1:0] data_q;
    logic [NUM_CH-1:0]        valid_q;
    logic                     done_q;

    assign last_shown = (beat_q == nbeats_q - 1'b1);

    // Beat generator: in IDLE it builds beat 0 straight from the command inputs.
    always_comb begin
        int idx, a;
        idx     = 0;
        a       = 0;
        g_data  = '0;
        g_valid = '0;
        if (state == IDLE) begin
            g_base = rd_addr_in;
            g_len  = rd_len_in;
            g_mode = rd_mode_e'(rd_col_mode_in);
            g_k    = 0;
        end else begin
            g_base = base_q;
            g_len  = len_q;
            g_mode = mode_q;
            g_k    = int'(beat_q) + 1;
        end
        g_rows = (int'(g_len) + NUM_CH - 1) / NUM_CH;
        g_last = (g_k == g_rows - 1);
        for (int c = 0; c < NUM_CH; c++) begin
            idx = (g_mode == COL) ? c * g_rows + g_k : g_k * NUM_CH + c;
            a   = int'(g_base) + idx;
            if (idx < int'(g_len) && a < DEPTH) begin
                g_valid[c] = 1'b1;
                g_data[lane_lsb(c, DATA_W) +: DATA_W] = mem[a[ADDR_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        adv     = 1'b0;
        case (state)
            IDLE: if (rd_start && rd_len_in != '0) begin
                state_n = READ;
                load    = 1'b1;
            end
            READ: if (last_shown) state_n = IDLE;
                  else            adv     = 1'b1;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            len_q    <= '0;
            mode_q   <= ROW;
            beat_q   <= '0;
            nbeats_q <= '0;
            data_q   <= '0;
            valid_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            if (load) begin
                base_q   <= rd_addr_in;
                len_q    <= rd_len_in;
                mode_q   <= g_mode;
                nbeats_q <= LEN_W'(g_rows);
                beat_q   <= '0;
            end else if (adv) begin
                beat_q <= beat_q + 1'b1;
            end
            if (load || adv) begin
                data_q  <= g_data;
                valid_q <= g_valid;
                done_q  <= g_last;
            end else begin
                data_q  <= '0;
                valid_q <= '0;
                done_q  <= 1'b0;
            end
        end
    end

`ifdef UB_SKEW_EN
    localparam int TAIL_W = $clog2(NUM_CH) + 1;
    logic [TAIL_W-1:0] tail;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        ub_lane_skew #(.WIDTH(DATA_W + 1), .DELAY(c)) u_skew (
            .clk  (clk),
            .rst  (rst),
            .din  ({valid_q[c], data_q[c*DATA_W +: DATA_W]}),
            .dout ({rd_valid_out[c], rd_data_out[c*DATA_W +: DATA_W]})
        );
    end

    ub_lane_skew #(.WIDTH(1), .DELAY(NUM_CH - 1)) u_done_skew (
        .clk  (clk),
        .rst  (rst),
        .din  (done_q),
        .dout (rd_done_out)
    );

    // Busy stays up until the most-delayed lane has drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 tail <= '0;
        else if (state == READ)  tail <= TAIL_W'(NUM_CH - 1);
        else if (tail != '0)     tail <= tail - 1'b1;
    end

    assign rd_busy_out = (state == READ) || (tail != '0);
`else
    assign rd_data_out  = data_q;
    assign rd_valid_out = valid_q;
    assign rd_done_out  = done_q;
    assign rd_busy_out  = (state == READ);
`endif

endmodule

// File: tb/tb_unified_buffer_mc.sv
// Directed bench for unified_buffer_mc at NUM_CH=2, DEPTH=64, DATA_W=16.
// Table-driven write and read vectors plus hand sequences for overflow and reset corners.
module tb_unified_buffer_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_start;
    logic [1:0]  wr_valid_in;
    logic [31:0] wr_data_in;
    logic [6:0]  wr_ptr_out;
    logic        wr_overflow_out;
    logic        rd_start;
    logic        rd_col_mode_in;
    logic [5:0]  rd_addr_in;
    logic [6:0]  rd_len_in;
    logic [31:0] rd_data_out;
    logic [1:0]  rd_valid_out;
    logic        rd_busy_out;
    logic        rd_done_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    unified_buffer_mc #(.DATA_W(16), .DEPTH(64), .NUM_CH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_start        (wr_start),
        .wr_valid_in     (wr_valid_in),
        .wr_data_in      (wr_data_in),
        .wr_ptr_out      (wr_ptr_out),
        .wr_overflow_out (wr_overflow_out),
        .rd_start        (rd_start),
        .rd_col_mode_in  (rd_col_mode_in),
        .rd_addr_in      (rd_addr_in),
        .rd_len_in       (rd_len_in),
        .rd_data_out     (rd_data_out),
        .rd_valid_out    (rd_valid_out),
        .rd_busy_out     (rd_busy_out),
        .rd_done_out     (rd_done_out)
    );

    typedef struct {
        logic        st;
        logic [1:0]  wv;
        logic [31:0] wd;
        logic [6:0]  ptr;
        logic        ovf;
    } wvec_t;

    typedef struct {
        logic        st;
        logic        mode;
        logic [5:0]  addr;
        logic [6:0]  len;
        logic [31:0] data;
        logic [1:0]  valid;
        logic        busy;
        logic        done;
    } rvec_t;

    wvec_t wt[9];
    rvec_t rt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] d, input logic [1:0] v,
                          input logic b, input logic dn);
        chk({tag, ".data"},  rd_data_out, d);
        chk({tag, ".valid"}, 32'(rd_valid_out), 32'(v));
        chk({tag, ".busy"},  32'(rd_busy_out), 32'(b));
        chk({tag, ".done"},  32'(rd_done_out), 32'(dn));
    endtask

    task automatic idle_inputs();
        wr_start       = 1'b0;
        wr_valid_in    = 2'b00;
        wr_data_in     = '0;
        rd_start       = 1'b0;
        rd_col_mode_in = 1'b0;
        rd_addr_in     = '0;
        rd_len_in      = '0;
    endtask

    initial begin
        // mem after table: 0:11 1:22 2:33 3:44 4:55 5:66 6:77 7:88 8:1 9:2 10:3 11:4
        wt[0] = '{1'b1, 2'b11, 32'h0022_0011, 7'd2,  1'b0};
        wt[1] = '{1'b1, 2'b10, 32'h0033_dead, 7'd3,  1'b0};
        wt[2] = '{1'b1, 2'b00, 32'hffff_ffff, 7'd3,  1'b0};
        wt[3] = '{1'b0, 2'b11, 32'haaaa_aaaa, 7'd3,  1'b0};
        wt[4] = '{1'b1, 2'b11, 32'h0055_0044, 7'd5,  1'b0};
        wt[5] = '{1'b1, 2'b11, 32'h0077_0066, 7'd7,  1'b0};
        wt[6] = '{1'b1, 2'b01, 32'hbeef_0088, 7'd8,  1'b0};
        wt[7] = '{1'b1, 2'b11, 32'h0002_0001, 7'd10, 1'b0};
        wt[8] = '{1'b1, 2'b11, 32'h0004_0003, 7'd12, 1'b0};

        // row read len 3, with a rd_start ignored mid-read
        rt[0]  = '{1'b1, 1'b0, 6'd0,  7'd3, 32'h0022_0011, 2'b11, 1'b1, 1'b0};
        rt[1]  = '{1'b1, 1'b0, 6'd8,  7'd4, 32'h0000_0033, 2'b01, 1'b1, 1'b1};
        rt[2]  = '{1'b0, 1'b0, 6'd0,  7'd0, 32'h0000_0000, 2'b00, 1'b0, 1'b0};
        // zero length ignored
        rt[3]  = '{1'b1, 1'b0, 6'd4,  7'd0, 32'h0000_0000, 2'b00, 1'b0, 1'b0};
        // column read base 8 len 4
        rt[4]  = '{1'b1, 1'b1, 6'd8,  7'd4, 32'h0003_0001, 2'b11, 1'b1, 1'b0};
        rt[5]  = '{1'b0, 1'b0, 6'd0,  7'd0, 32'h0004_0002, 2'b11, 1'b1, 1'b1};
        rt[6]  = '{1'b0, 1'b0, 6'd0,  7'd0, 32'h0000_0000, 2'b00, 1'b0, 1'b0};
        // row read running past the end of memory
        rt[7]  = '{1'b1, 1'b0, 6'd62, 7'd4, 32'h0000_0000, 2'b11, 1'b1, 1'b0};
        rt[8]  = '{1'b0, 1'b0, 6'd0,  7'd0, 32'h0000_0000, 2'b00, 1'b1, 1'b1};
        rt[9]  = '{1'b0, 1'b0, 6'd0,  7'd0, 32'h0000_0000, 2'b00, 1'b0, 1'b0};
        // column read odd length: R=2, lane1 beat1 index 3 >= len
        rt[10] = '{1'b1, 1'b1, 6'd0,  7'd3, 32'h0033_0011, 2'b11, 1'b1, 1'b0};
        rt[11] = '{1'b0, 1'b0, 6'd0,  7'd0, 32'h0000_0022, 2'b01, 1'b1, 1'b1};
        rt[12] = '{1'b0, 1'b0, 6'd0,  7'd0, 32'h0000_0000, 2'b00, 1'b0, 1'b0};
        // single-beat read
        rt[13] = '{1'b1, 1'b0, 6'd9,  7'd1, 32'h0000_0002, 2'b01, 1'b1, 1'b1};
        rt[14] = '{1'b0, 1'b0, 6'd0,  7'd0, 32'h0000_0000, 2'b00, 1'b0, 1'b0};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.wr_ptr", 32'(wr_ptr_out), 32'd0);
        chk("reset.ovf", 32'(wr_overflow_out), 32'd0);
        chk_rd("reset", 32'h0, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            wr_start    = wt[i].st;
            wr_valid_in = wt[i].wv;
            wr_data_in  = wt[i].wd;
            tick();
            chk($sformatf("wr%0d.ptr", i), 32'(wr_ptr_out), 32'(wt[i].ptr));
            chk($sformatf("wr%0d.ovf", i), 32'(wr_overflow_out), 32'(wt[i].ovf));
        end
        idle_inputs();

        for (int i = 0; i < 15; i++) begin
            rd_start       = rt[i].st;
            rd_col_mode_in = rt[i].mode;
            rd_addr_in     = rt[i].addr;
            rd_len_in      = rt[i].len;
            tick();
            chk_rd($sformatf("rd%0d", i), rt[i].data, rt[i].valid, rt[i].busy, rt[i].done);
        end
        idle_inputs();

        // same-edge read and write of address 12: read sees the old value
        wr_start = 1'b1; wr_valid_in = 2'b01; wr_data_in = 32'h0000_0099;
        rd_start = 1'b1; rd_addr_in = 6'd12; rd_len_in = 7'd1;
        tick();
        idle_inputs();
        chk_rd("rdw.old", 32'h0, 2'b01, 1'b1, 1'b1);
        chk("rdw.ptr", 32'(wr_ptr_out), 32'd13);
        tick();
        rd_start = 1'b1; rd_addr_in = 6'd12; rd_len_in = 7'd1;
        tick();
        idle_inputs();
        chk_rd("rdw.new", 32'h0000_0099, 2'b01, 1'b1, 1'b1);
        tick();

        // fill addresses 13..62
        for (int i = 0; i < 25; i++) begin
            wr_start    = 1'b1;
            wr_valid_in = 2'b11;
            wr_data_in  = {16'(200 + i), 16'(100 + i)};
            tick();
        end
        idle_inputs();
        chk("fill.ptr", 32'(wr_ptr_out), 32'd63);

        wr_start = 1'b1; wr_valid_in = 2'b11; wr_data_in = 32'h1111_2222;
        tick();
        idle_inputs();
        chk("full.ovf", 32'(wr_overflow_out), 32'd1);
        chk("full.ptr", 32'(wr_ptr_out), 32'd63);
        tick();
        chk("full.ovf_clear", 32'(wr_overflow_out), 32'd0);

        wr_start = 1'b1; wr_valid_in = 2'b10; wr_data_in = 32'hbeef_0000;
        tick();
        idle_inputs();
        chk("last.ovf", 32'(wr_overflow_out), 32'd0);
        chk("last.ptr", 32'(wr_ptr_out), 32'd64);

        wr_start = 1'b1; wr_valid_in = 2'b01; wr_data_in = 32'h0000_5555;
        tick();
        idle_inputs();
        chk("past.ovf", 32'(wr_overflow_out), 32'd1);
        chk("past.ptr", 32'(wr_ptr_out), 32'd64);

        rd_start = 1'b1; rd_addr_in = 6'd62; rd_len_in = 7'd2;
        tick();
        idle_inputs();
        chk_rd("top2", 32'hbeef_00e0, 2'b11, 1'b1, 1'b1);
        tick();

        // reset in the middle of a 4-beat read
        rd_start = 1'b1; rd_addr_in = 6'd0; rd_len_in = 7'd8;
        tick();
        idle_inputs();
        chk_rd("mid.beat0", 32'h0022_0011, 2'b11, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk_rd("mid.rst", 32'h0, 2'b00, 1'b0, 1'b0);
        chk("mid.rst.ptr", 32'(wr_ptr_out), 32'd0);
        #2 rst = 1'b0;
        rd_start = 1'b1; rd_addr_in = 6'd0; rd_len_in = 7'd2;
        tick();
        idle_inputs();
        chk_rd("mid.zeroed", 32'h0, 2'b11, 1'b1, 1'b1);
        tick();
        chk_rd("mid.after", 32'h0, 2'b00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
